// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter for eight requesters sharing one 8-to-1 select lane.
// Ownership is bounded to MAX_HOLD cycles while others wait; the selected lane is registered.
module mux8_rr_arbiter #(
    parameter int DW       = 1,
    parameter int MAX_HOLD = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [7:0]      req,
    input  logic [8*DW-1:0] d,
    output logic [7:0]      gnt,
    output logic [2:0]      sel,
    output logic            busy,
    output logic [DW-1:0]   dout,
    output logic            dout_valid
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_e        state_q, state_d;
    logic [2:0]    sel_q, sel_d;
    logic [2:0]    ptr_q, ptr_d;
    logic [7:0]    hcnt_q, hcnt_d;
    logic [DW-1:0] dout_q;
    logic          dv_q;

    logic [7:0]    owner_oh;
    logic [7:0]    others;
    logic [2:0]    nxt_ptr;
    logic          own_req;
    logic          any_other;
    logic          hold_done;

    // First set bit of mask at or after start, scanning circularly.
    function automatic logic [2:0] rr_pick(
        input logic [7:0] mask,
        input logic [2:0] start
    );
        logic [7:0] rot;
        logic [2:0] off;
        rot = 8'({mask, mask} >> start);
        off = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (rot[i]) off = 3'(i);
        end
        return start + off;
    endfunction

    assign owner_oh  = 8'b1 << sel_q;
    assign others    = req & ~owner_oh;
    assign own_req   = |(req & owner_oh);
    assign any_other = |others;
    assign hold_done = (hcnt_q == HOLD_LAST);
    assign nxt_ptr   = sel_q + 3'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= 3'd0;
            ptr_q   <= 3'd0;
            hcnt_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            hcnt_q  <= hcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        hcnt_d  = hcnt_q;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = GRANT;
                    sel_d   = rr_pick(req, ptr_q);
                    hcnt_d  = 8'd0;
                end
            end
            GRANT: begin
                if (!own_req) begin
                    ptr_d  = nxt_ptr;
                    hcnt_d = 8'd0;
                    if (any_other) sel_d = rr_pick(others, nxt_ptr);
                    else state_d = IDLE;
                end else if (hold_done) begin
                    // A lone owner simply reloads its hold budget.
                    hcnt_d = 8'd0;
                    if (any_other) begin
                        ptr_d = nxt_ptr;
                        sel_d = rr_pick(others, nxt_ptr);
                    end
                end else begin
                    hcnt_d = hcnt_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy = (state_q == GRANT);
        gnt  = busy ? owner_oh : 8'h00;
        sel  = sel_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
            dv_q   <= 1'b0;
        end else begin
            dv_q <= busy;
            if (busy) dout_q <= d[sel_q*DW +: DW];
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dv_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Bench for mux8_rr_arbiter: three parameterisations checked every cycle
// against a behavioural model, plus directed literal expectations.
module tb_mux8_rr_arbiter;

    logic        clk;
    logic        rst_n;
    logic [7:0]  req;
    logic [7:0]  d8;
    logic [31:0] d32;

    logic [7:0]  gnt_a, gnt_b, gnt_c;
    logic [2:0]  sel_a, sel_b, sel_c;
    logic        busy_a, busy_b, busy_c;
    logic        dout_a, dout_b;
    logic [3:0]  dout_c;
    logic        dv_a, dv_b, dv_c;

    int nchk = 0;
    int nerr = 0;
    bit chk_on = 0;

    int owner[3];
    int ptr[3];
    int held[3];
    int msel[3];
    int mdout[3];
    int mdv[3];
    int mh[3]  = '{4, 1, 3};
    int dwv[3] = '{1, 1, 4};

    int t2a[12] = '{0,0,0,0,4,4,4,4,0,0,0,0};
    int t2b[12] = '{0,4,0,4,0,4,0,4,0,4,0,4};
    int t4d[8]  = '{0,1,1,0,1,0,0,1};

    mux8_rr_arbiter #(.DW(1), .MAX_HOLD(4)) u_a (
        .clk(clk), .rst_n(rst_n), .req(req), .d(d8),
        .gnt(gnt_a), .sel(sel_a), .busy(busy_a),
        .dout(dout_a), .dout_valid(dv_a)
    );

    mux8_rr_arbiter #(.DW(1), .MAX_HOLD(1)) u_b (
        .clk(clk), .rst_n(rst_n), .req(req), .d(d8),
        .gnt(gnt_b), .sel(sel_b), .busy(busy_b),
        .dout(dout_b), .dout_valid(dv_b)
    );

    mux8_rr_arbiter #(.DW(4), .MAX_HOLD(3)) u_c (
        .clk(clk), .rst_n(rst_n), .req(req), .d(d32),
        .gnt(gnt_c), .sel(sel_c), .busy(busy_c),
        .dout(dout_c), .dout_valid(dv_c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int scan(int mask, int start);
        for (int k = 0; k < 8; k++) begin
            if (((mask >> ((start + k) % 8)) & 1) != 0) return (start + k) % 8;
        end
        return -1;
    endfunction

    function automatic void model_reset(int k);
        owner[k] = -1;
        ptr[k]   = 0;
        held[k]  = 0;
        msel[k]  = 0;
        mdout[k] = 0;
        mdv[k]   = 0;
    endfunction

    // held = number of cycles the current owner has had the grant so far
    function automatic void model_step(int k, int r, int dv);
        int pb;
        int ps;
        int oth;
        pb = (owner[k] >= 0) ? 1 : 0;
        ps = msel[k];
        if (owner[k] < 0) begin
            if (r != 0) begin
                owner[k] = scan(r, ptr[k]);
                held[k]  = 1;
            end
        end else begin
            oth = r & ~(1 << owner[k]);
            if (((r >> owner[k]) & 1) == 0) begin
                ptr[k] = (owner[k] + 1) % 8;
                if (oth != 0) begin
                    owner[k] = scan(oth, ptr[k]);
                    held[k]  = 1;
                end else begin
                    owner[k] = -1;
                end
            end else if (held[k] == mh[k]) begin
                if (oth != 0) begin
                    ptr[k]   = (owner[k] + 1) % 8;
                    owner[k] = scan(oth, ptr[k]);
                end
                held[k] = 1;
            end else begin
                held[k]++;
            end
        end
        if (owner[k] >= 0) msel[k] = owner[k];
        mdv[k] = pb;
        if (pb != 0) mdout[k] = (dv >> (ps * dwv[k])) & ((1 << dwv[k]) - 1);
    endfunction

    function automatic void cmp(int k, logic [7:0] g, logic [2:0] s,
                                logic b, logic [3:0] o, logic v);
        logic [7:0] eg;
        eg = (owner[k] >= 0) ? 8'(1 << owner[k]) : 8'h00;
        check($sformatf("m%0d.gnt", k), 32'(g), 32'(eg));
        check($sformatf("m%0d.sel", k), 32'(s), msel[k]);
        check($sformatf("m%0d.busy", k), 32'(b), (owner[k] >= 0) ? 1 : 0);
        check($sformatf("m%0d.dout", k), 32'(o), mdout[k]);
        check($sformatf("m%0d.dout_valid", k), 32'(v), mdv[k]);
    endfunction

    initial begin
        for (int k = 0; k < 3; k++) model_reset(k);
        forever begin
            @(posedge clk or negedge rst_n);
            for (int k = 0; k < 3; k++) begin
                if (!rst_n) model_reset(k);
                else model_step(k, int'(req), (k == 2) ? int'(d32) : int'(d8));
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                cmp(0, gnt_a, sel_a, busy_a, {3'b000, dout_a}, dv_a);
                cmp(1, gnt_b, sel_b, busy_b, {3'b000, dout_b}, dv_b);
                cmp(2, gnt_c, sel_c, busy_c, dout_c, dv_c);
            end
        end
    end

    task automatic restart();
        @(negedge clk);
        #2 rst_n = 1'b0;
        req = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        req   = 8'h00;
        d8    = 8'h00;
        d32   = 32'h0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk_on = 1;
        check("rst.gnt", 32'(gnt_a), 0);
        check("rst.sel", 32'(sel_a), 0);
        check("rst.busy", 32'(busy_a), 0);
        check("rst.dout", 32'(dout_a), 0);
        check("rst.dv", 32'(dv_a), 0);

        // single request, held three cycles
        restart();
        req = 8'h04;
        d8  = 8'h04;
        d32 = $urandom;
        @(negedge clk);
        check("t1.gnt", 32'(gnt_a), 32'h04);
        check("t1.sel", 32'(sel_a), 2);
        check("t1.busy", 32'(busy_a), 1);
        @(negedge clk);
        check("t1.dout", 32'(dout_a), 1);
        check("t1.dv", 32'(dv_a), 1);
        @(negedge clk);
        req = 8'h00;
        @(negedge clk);
        check("t1.idle_gnt", 32'(gnt_a), 0);
        check("t1.idle_busy", 32'(busy_a), 0);
        check("t1.last_dv", 32'(dv_a), 1);
        check("t1.sel_hold", 32'(sel_a), 2);
        @(negedge clk);
        check("t1.dv_low", 32'(dv_a), 0);
        check("t1.dout_hold", 32'(dout_a), 1);

        // two-way rotation
        restart();
        req = 8'h11;
        d8  = 8'($urandom);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check($sformatf("t2.sel_a[%0d]", i), 32'(sel_a), t2a[i]);
            check($sformatf("t2.sel_b[%0d]", i), 32'(sel_b), t2b[i]);
        end

        // wrap-around from requester 7 to 0 without a bubble
        restart();
        req = 8'h80;
        @(negedge clk);
        check("t3.sel7", 32'(sel_a), 7);
        req = 8'h01;
        @(negedge clk);
        check("t3.sel0", 32'(sel_a), 0);
        check("t3.busy", 32'(busy_a), 1);
        req = 8'h81;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("t3.hold[%0d]", i), 32'(sel_a), 0);
        end
        @(negedge clk);
        check("t3.rot7", 32'(gnt_a), 32'h80);

        // all requesting, MAX_HOLD=1
        restart();
        req = 8'hFF;
        d8  = 8'b1001_0110;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i < 9) check($sformatf("t4.sel[%0d]", i), 32'(sel_b), i % 8);
            if (i >= 1) check($sformatf("t4.dout[%0d]", i), 32'(dout_b), t4d[(i - 1) % 8]);
        end

        // lone owner past MAX_HOLD
        restart();
        req = 8'h20;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("t5.gnt[%0d]", i), 32'(gnt_a), 32'h20);
        end

        // async reset mid-grant
        restart();
        req = 8'h08;
        d8  = 8'h08;
        @(negedge clk);
        check("t6.gnt", 32'(gnt_a), 32'h08);
        @(negedge clk);
        check("t6.dout", 32'(dout_a), 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6.r_gnt", 32'(gnt_a), 0);
        check("t6.r_sel", 32'(sel_a), 0);
        check("t6.r_busy", 32'(busy_a), 0);
        check("t6.r_dout", 32'(dout_a), 0);
        check("t6.r_dv", 32'(dv_a), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t6.regnt", 32'(gnt_a), 32'h08);
        check("t6.resel", 32'(sel_a), 3);

        // randomized traffic
        restart();
        for (int i = 0; i < 4000 && nerr < 20; i++) begin
            @(negedge clk);
            case ($urandom_range(0, 5))
                0: req = 8'($urandom);
                1: req = req & 8'($urandom);
                2: req = req | (8'h01 << $urandom_range(0, 7));
                default: ;
            endcase
            d8  = 8'($urandom);
            d32 = $urandom;
            if ($urandom_range(0, 599) == 0) begin
                #2 rst_n = 1'b0;
                #4 rst_n = 1'b1;
            end
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for the 8-to-1 select datapath.
- Eight requesters share one output lane.
- The block arbitrates their requests, drives the 3-bit select, and returns one-hot grants.
- It registers the selected data lane, and enforces a maximum hold time so that no requester starves the others.

Parameters:
DW, 1, data width of each requester lane (the selected lane goes to dout).
MAX_HOLD, 4, maximum consecutive grant cycles before forced rotation when other requests are pending; legal range 1..255.

Ports:
clk  input  1  system clock, all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
req  input  8  request per requester; bit i = requester i.
d  input  8*DW  packed data lanes; lane i = d[i*DW +: DW].
gnt  output  8  one-hot grant, all-zero when idle.
sel  output  3  select index of current owner, drives the 8-to-1 select.
busy  output  1  high while in GRANT state.
dout  output  DW  registered copy of the selected lane.
dout_valid  output  1  high when dout holds data sampled during a grant cycle.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; gnt=0, sel=0, busy=0, dout=0, dout_valid=0.
  - Priority pointer ptr=0; hold counter hcnt=0.
  - Reset takes effect immediately mid-grant. No grant survives reset.
- FSM states: IDLE, GRANT.
- Winner search: circular scan of a candidate mask starting at ptr (ptr, ptr+1, ... 7, 0, ... ptr-1); the first set bit wins.
- IDLE:
  - If req==0, stay IDLE.
  - Otherwise, at the next edge: sel=winner, gnt=1<<winner, hcnt=0, state=GRANT.
  - Latency from req to gnt is 1 cycle.
- GRANT, evaluated each edge, where owner=sel:
  - (a) req[owner]=0 (release):
    - ptr=owner+1 mod 8.
    - If any other req is set, grant the new winner at the same edge, with the search starting at owner+1. There is no idle bubble; hcnt=0.
    - Otherwise gnt=0 and state=IDLE.
  - (b) req[owner]=1 and hcnt=MAX_HOLD-1 and another req is set (forced rotation):
    - ptr=owner+1 mod 8.
    - The new winner is chosen from req with the owner bit masked; hcnt=0.
  - (c) req[owner]=1 and hcnt=MAX_HOLD-1 and no other req: owner keeps the grant and hcnt=0.
  - (d) Otherwise the grant is unchanged and hcnt=hcnt+1.
- Wrap-around: ptr and the search wrap 7 to 0 (modulo-8 arithmetic on 3 bits).
- Grant invariants: gnt is always one-hot or zero, and gnt==(busy ? 1<<sel : 0). sel holds its last value while IDLE.
- Data path:
  - Each edge: dout_valid<=busy (pre-edge value).
  - If busy (pre-edge), dout<=d lane[sel] (pre-edge sel). Otherwise dout holds.
  - dout therefore lags the grant by exactly 1 cycle.
- Requester protocol:
  - A requester holds req until it sees its gnt bit, then drops req to release.
  - Requests may change on any cycle; a req deasserted before it is granted is simply not served.
- Simultaneous events:
  - Owner release and a new request arriving on the same edge: the new request participates in that edge's search.
  - MAX_HOLD=1: every cycle with other pending requests rotates the grant.

Test Plan:
1. Single request, DW=1:
   - req=8'h04, d=8'b0000_0100, held 3 cycles, then req=0.
   - gnt=8'h04, sel=2 one edge after req; busy=1 for 3 cycles.
   - dout=1, dout_valid=1 one cycle after each grant cycle; then IDLE with gnt=0.
2. Two-way rotation, MAX_HOLD=4:
   - req=8'h11 held continuously from reset.
   - Grant pattern: requester 0 for 4 cycles, requester 4 for 4, requester 0 for 4, and so on.
   - ptr goes to 1, then to 5.
3. Wrap-around:
   - After requester 7 releases, req=8'h81 is pending with ptr=0 (7+1 mod 8).
   - Requester 0 is granted with no bubble cycle; its next forced rotation goes to requester 7.
4. All request, MAX_HOLD=1:
   - req=8'hFF held.
   - sel sequences 0,1,2,...,7,0 with one cycle each; gnt is always one-hot.
   - dout tracks d lane[sel] one cycle later; d=8'b1001_0110 gives dout 0,1,1,0,1,0,0,1.
5. Lone owner past MAX_HOLD:
   - req=8'h20 held 10 cycles with MAX_HOLD=4.
   - gnt stays 8'h20 for all 10 cycles (hcnt reloads), with no gap.
6. Reset mid-grant:
   - While gnt=8'h08, assert rst_n=0 between clock edges.
   - gnt, sel, busy, dout, dout_valid go to 0 immediately.
   - After release with req=8'h08 still held: gnt=8'h08 one edge later, searching from ptr=0.
